// File: rtl/pn_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : pn_rx_checker
// Description : Receive-end checker for the x^8+x^4+x^3+x^2+1 PN test stream.
//               It self-synchronises to the incoming NRZ bits, then flywheels
//               a local replica and counts bit errors for BER measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module pn_rx_checker #(
    parameter int LOCK_CNT = 16,  // consecutive VERIFY matches needed to lock
    parameter int WINDOW   = 64,  // strobed bits per loss-of-lock window
    parameter int LOSS_ERR = 8,   // errors within one window that drop lock
    parameter int CNT_W    = 16   // width of the BER counters
) (
    input  logic             clk,
    input  logic             areset,   // asynchronous, active-low
    input  logic             oen,      // bit strobe, active-low
    input  logic             d,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W   = $clog2(WINDOW + 1);
    localparam int c_WERR_W  = $clog2(LOSS_ERR + 1);

    localparam logic [1:0] c_ST_FILL   = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
    localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(WINDOW - 1);
    localparam logic [c_WERR_W-1:0]  c_WERR_LAST  = c_WERR_W'(LOSS_ERR - 1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]          r_state,   w_state_nxt;
    logic [7:0]          r_hist,    w_hist_nxt;
    logic [2:0]          r_fill,    w_fill_nxt;
    logic [c_MATCH_W-1:0] r_match,  w_match_nxt;
    logic [c_WIN_W-1:0]  r_win,     w_win_nxt;
    logic [c_WERR_W-1:0] r_win_err, w_win_err_nxt;
    logic                r_err,     w_err_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                w_pred;
    logic                w_miss;
    logic                w_bit_inc;
    logic                w_err_inc;

    // Next bit predicted from the history: b(n-2)^b(n-3)^b(n-4)^b(n-8).
    assign w_pred = r_hist[1] ^ r_hist[2] ^ r_hist[3] ^ r_hist[7];
    assign w_miss = d ^ w_pred;

    // Acquisition / flywheel state machine; everything holds unless strobed.
    always_comb begin
        w_state_nxt   = r_state;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_nxt     = r_win;
        w_win_err_nxt = r_win_err;
        w_err_nxt     = 1'b0;
        w_bit_inc     = 1'b0;
        w_err_inc     = 1'b0;
        if (!oen) begin
            case (r_state)
                c_ST_FILL: begin
                    w_hist_nxt = {r_hist[6:0], d};
                    w_fill_nxt = r_fill + 3'd1;
                    if (r_fill == 3'd7) begin
                        w_state_nxt = c_ST_VERIFY;
                        w_fill_nxt  = 3'd0;
                        w_match_nxt = '0;
                    end
                end
                c_ST_VERIFY: begin
                    // Self-sync: received bits feed the history. An all-zero
                    // history predicts zero forever, so it never counts.
                    w_hist_nxt = {r_hist[6:0], d};
                    if (!w_miss && (r_hist != 8'd0)) begin
                        if (r_match == c_MATCH_LAST) begin
                            w_state_nxt   = c_ST_LOCKED;
                            w_match_nxt   = '0;
                            w_win_nxt     = '0;
                            w_win_err_nxt = '0;
                        end else begin
                            w_match_nxt = r_match + 1'b1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                c_ST_LOCKED: begin
                    // Flywheel: the prediction feeds the history so a single
                    // line error costs exactly one counted error.
                    w_hist_nxt = {r_hist[6:0], w_pred};
                    w_bit_inc  = 1'b1;
                    w_win_nxt  = r_win + 1'b1;
                    if (w_miss) begin
                        w_err_nxt     = 1'b1;
                        w_err_inc     = 1'b1;
                        w_win_err_nxt = r_win_err + 1'b1;
                    end
                    if (w_miss && (r_win_err == c_WERR_LAST)) begin
                        w_state_nxt = c_ST_FILL;
                        w_fill_nxt  = 3'd0;
                    end else if (r_win == c_WIN_LAST) begin
                        w_win_nxt     = '0;
                        w_win_err_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_FILL;
                    w_fill_nxt  = 3'd0;
                end
            endcase
        end
    end

    // State, history and window registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state   <= c_ST_FILL;
            r_hist    <= 8'd0;
            r_fill    <= 3'd0;
            r_match   <= '0;
            r_win     <= '0;
            r_win_err <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_win     <= w_win_nxt;
            r_win_err <= w_win_err_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Saturating BER counters; clr wins over a same-cycle increment and acts
    // whether or not a bit is strobed.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (clr) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_bit_inc && (r_bit_cnt != c_CNT_MAX)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_err_inc && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign locked  = (r_state == c_ST_LOCKED);
    assign err     = r_err;
    assign bit_cnt = r_bit_cnt;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire
